// File: rtl/systolic_stream_ctrl_pkg.sv
// Shared types for the systolic stream start controller: FSM state encoding
// and the staging-buffer depth helper.
package systolic_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } ctrl_state_e;

  function automatic int unsigned buf_depth(input int unsigned addrWidth);
    return 32'd1 << addrWidth;
  endfunction

endpackage

// File: rtl/systolic_stream_ctrl_tracker.sv
// Per-channel staging-buffer tracker: write pointer, occupancy, beat count,
// back-pressure, sticky start-qualify flag and a protocol-error strobe.
module stream_chan_tracker
  import systolic_ctrl_pkg::*;
#(
  parameter int BUFFER_ADDRESS_WIDTH = 10,
  parameter int COUNT_WIDTH          = 32,
  parameter int THRESH_SHIFT         = 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            clear_i,
  input  logic                            active_i,
  input  logic [COUNT_WIDTH-1:0]          total_i,
  input  logic                            valid_i,
  input  logic                            rd_i,
  output logic [BUFFER_ADDRESS_WIDTH-1:0] addr_o,
  output logic                            ready_o,
  output logic                            qualify_o,
  output logic                            zero_o,
  output logic                            err_o
);

  localparam int unsigned DEPTH = buf_depth(BUFFER_ADDRESS_WIDTH);
  localparam int OW = BUFFER_ADDRESS_WIDTH + 1;
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);
  localparam logic [OW-1:0] OCC_HALF = OW'(DEPTH / 2);

  logic [COUNT_WIDTH-1:0]          total_q;
  logic [COUNT_WIDTH-1:0]          beats_q, beats_d;
  logic [OW-1:0]                   occ_q, occ_d;
  logic [BUFFER_ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
  logic                            qual_q, qual_d;
  logic                            wrAcc, rdAcc;

  // Qualify looks at the post-update counts so the flag rises on the same
  // edge as the beat that satisfies it.
  always_comb begin
    ready_o = active_i && (occ_q < OCC_FULL) && (beats_q < total_q);
    wrAcc   = valid_i && ready_o;
    rdAcc   = active_i && rd_i && (occ_q != '0);
    err_o   = active_i && ((valid_i && !ready_o) || (rd_i && (occ_q == '0)));
    beats_d = beats_q + COUNT_WIDTH'(wrAcc);
    ptr_d   = ptr_q + BUFFER_ADDRESS_WIDTH'(wrAcc);
    occ_d   = occ_q;
    if (wrAcc && !rdAcc) begin
      occ_d = occ_q + OW'(1);
    end else if (!wrAcc && rdAcc) begin
      occ_d = occ_q - OW'(1);
    end
    qual_d = qual_q || (occ_d >= OCC_HALF) || (beats_d >= (total_q >> THRESH_SHIFT))
             || (beats_d == total_q) || (total_q == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      total_q <= '0;
      beats_q <= '0;
      occ_q   <= '0;
      ptr_q   <= '0;
      qual_q  <= 1'b0;
    end else if (clear_i) begin
      total_q <= total_i;
      beats_q <= '0;
      occ_q   <= '0;
      ptr_q   <= '0;
      qual_q  <= 1'b0;
    end else if (active_i) begin
      beats_q <= beats_d;
      occ_q   <= occ_d;
      ptr_q   <= ptr_d;
      qual_q  <= qual_d;
    end
  end

  assign addr_o    = ptr_q;
  assign qualify_o = qual_q;
  assign zero_o    = (total_q == '0);

endmodule

// File: rtl/systolic_stream_ctrl.sv
// Systolic array start controller: tracks NUM_CH operand streams, decides when
// the array may run and sequences one job from start to completion.
module systolic_stream_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int NUM_CH               = 2,
  parameter int BUFFER_ADDRESS_WIDTH = 10,
  parameter int COUNT_WIDTH          = 32,
  parameter int THRESH_SHIFT         = 1
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   start_i,
  input  logic [NUM_CH*COUNT_WIDTH-1:0]          total_beats_i,
  input  logic                                   start_all_i,
  input  logic [NUM_CH-1:0]                      valid_i,
  input  logic [NUM_CH-1:0]                      rd_i,
  output logic [NUM_CH*BUFFER_ADDRESS_WIDTH-1:0] buf_addr_o,
  output logic [NUM_CH-1:0]                      ready_o,
  output logic                                   array_start_o,
  input  logic                                   data_done_i,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic                                   err_o
);

  ctrl_state_e       state_q, state_d;
  logic              arrStart_q;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [NUM_CH-1:0] qualify, zeroTot, chanErr;
  logic              busy, startAcc, startOk;

  assign busy     = (state_q != IDLE);
  assign startAcc = (state_q == IDLE) && start_i;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    stream_chan_tracker #(
      .BUFFER_ADDRESS_WIDTH(BUFFER_ADDRESS_WIDTH),
      .COUNT_WIDTH         (COUNT_WIDTH),
      .THRESH_SHIFT        (THRESH_SHIFT)
    ) u_trk (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear_i  (startAcc),
      .active_i (busy),
      .total_i  (total_beats_i[c*COUNT_WIDTH +: COUNT_WIDTH]),
      .valid_i  (valid_i[c]),
      .rd_i     (rd_i[c]),
      .addr_o   (buf_addr_o[c*BUFFER_ADDRESS_WIDTH +: BUFFER_ADDRESS_WIDTH]),
      .ready_o  (ready_o[c]),
      .qualify_o(qualify[c]),
      .zero_o   (zeroTot[c]),
      .err_o    (chanErr[c])
    );
  end

  // Relaxed mode needs channel 0 (the A operand) plus any one other stream.
  assign startOk = start_all_i ? (&qualify) : (qualify[0] && (|qualify[NUM_CH-1:1]));

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (data_done_i) begin
          state_d = IDLE;
        end else if (&zeroTot) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (startOk) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (data_done_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if ((busy && start_i) || (|chanErr)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      arrStart_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      arrStart_q <= (state_d == RUN);
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign array_start_o = arrStart_q;
  assign busy_o        = busy;
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule
